// File: rtl/proc_ctrl_seq_if.sv
`default_nettype none
// proc_ctrl_seq_if: memory / datapath bundle around the control sequencer.
// Rev 1.0
interface proc_ctrl_seq_if #(
  parameter int DATA_W   = 32,
  parameter int ALU_OP_W = 6
);
  logic [DATA_W-1:0]   INSTRUCTION;
  logic                ZERO;
  logic                MEM_RDY;
  logic                READ;
  logic                WRITE;
  logic                IR_LOAD;
  logic                PC_INC;
  logic                PC_LOAD;
  logic                REG_WE;
  logic                WB_SEL_MEM;
  logic                ALU_SRC_IMM;
  logic [ALU_OP_W-1:0] ALU_OP;
  logic [2:0]          STATE;
  logic                HALTED;
  logic [1:0]          ERR;

  modport master (
    input  INSTRUCTION, ZERO, MEM_RDY,
    output READ, WRITE, IR_LOAD, PC_INC, PC_LOAD, REG_WE, WB_SEL_MEM,
           ALU_SRC_IMM, ALU_OP, STATE, HALTED, ERR
  );

  modport slave (
    output INSTRUCTION, ZERO, MEM_RDY,
    input  READ, WRITE, IR_LOAD, PC_INC, PC_LOAD, REG_WE, WB_SEL_MEM,
           ALU_SRC_IMM, ALU_OP, STATE, HALTED, ERR
  );
endinterface
`default_nettype wire

// File: rtl/proc_ctrl_seq.sv
`default_nettype none
// proc_ctrl_seq: multi-cycle FETCH/DECODE/EXE/MEM/WB control sequencer with MEM_RDY handshake.
// Rev 1.0
module proc_ctrl_seq #(
  parameter int DATA_W      = 32,
  parameter int ALU_OP_W    = 6,
  parameter int MEM_TIMEOUT = 15,
  parameter int SKIP_MEM    = 1
) (
  input  logic           CLK,
  input  logic           RST,
  proc_ctrl_seq_if.master bus
);

  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXE    = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  typedef enum logic [3:0] {
    K_NONE, K_RALU, K_JR, K_IARITH, K_LW, K_SW, K_BEQ, K_BNE, K_J, K_JAL
  } kind_t;

  state_t            state, state_nx;
  logic              started;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [1:0]        err, err_nx;

  logic [DATA_W-1:0] ir;
  kind_t             kind, dec_kind;
  logic [3:0]        alu, dec_alu;
  logic              imm, dec_imm, dec_bad, dec_halt;
  logic              zero_q;
  logic              mem_access, waiting;
  logic              unused_ir_bits;

  logic              read, write, ir_load, pc_inc, pc_load, reg_we, wb_sel_mem, alu_src_imm, halted;
  logic [ALU_OP_W-1:0] alu_op;

  assign unused_ir_bits = ^ir;

  always_comb begin
    dec_kind = K_NONE;
    dec_alu  = 4'd0;
    dec_imm  = 1'b0;
    dec_bad  = 1'b0;
    dec_halt = 1'b0;
    case (ir[31:26])
      6'h00: begin
        dec_kind = K_RALU;
        case (ir[5:0])
          6'h20: dec_alu = 4'd1;
          6'h22: dec_alu = 4'd2;
          6'h2c: dec_alu = 4'd3;
          6'h02: dec_alu = 4'd4;
          6'h01: dec_alu = 4'd5;
          6'h24: dec_alu = 4'd6;
          6'h25: dec_alu = 4'd7;
          6'h27: dec_alu = 4'd8;
          6'h2a: dec_alu = 4'd9;
          6'h08: dec_kind = K_JR;
          default: dec_bad = 1'b1;
        endcase
      end
      6'h08: begin dec_kind = K_IARITH; dec_alu = 4'd1; dec_imm = 1'b1; end
      6'h1d: begin dec_kind = K_IARITH; dec_alu = 4'd3; dec_imm = 1'b1; end
      6'h0c: begin dec_kind = K_IARITH; dec_alu = 4'd6; dec_imm = 1'b1; end
      6'h0d: begin dec_kind = K_IARITH; dec_alu = 4'd7; dec_imm = 1'b1; end
      6'h0a: begin dec_kind = K_IARITH; dec_alu = 4'd9; dec_imm = 1'b1; end
      6'h23: begin dec_kind = K_LW;     dec_alu = 4'd1; dec_imm = 1'b1; end
      6'h2b: begin dec_kind = K_SW;     dec_alu = 4'd1; dec_imm = 1'b1; end
      6'h04: begin dec_kind = K_BEQ;    dec_alu = 4'd2; end
      6'h05: begin dec_kind = K_BNE;    dec_alu = 4'd2; end
      6'h02: dec_kind = K_J;
      6'h03: dec_kind = K_JAL;
      6'h3f: dec_halt = 1'b1;
      default: dec_bad = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= S_IDLE;
      cnt     <= '0;
      err     <= 2'b00;
      started <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      err     <= err_nx;
      started <= 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ir     <= '0;
      kind   <= K_NONE;
      alu    <= 4'd0;
      imm    <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      if (ir_load) ir <= bus.INSTRUCTION;
      if (state == S_DECODE) begin
        kind <= dec_kind;
        alu  <= dec_alu;
        imm  <= dec_imm;
      end
      if (state == S_EXE) zero_q <= bus.ZERO;
    end
  end

  assign mem_access = (kind == K_LW) || (kind == K_SW);
  assign waiting    = (state == S_FETCH) || ((state == S_MEM) && mem_access);

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    err_nx      = err;
    read        = 1'b0;
    write       = 1'b0;
    ir_load     = 1'b0;
    pc_inc      = 1'b0;
    pc_load     = 1'b0;
    reg_we      = 1'b0;
    wb_sel_mem  = 1'b0;
    alu_src_imm = 1'b0;
    alu_op      = '0;
    halted      = 1'b0;
    case (state)
      S_IDLE:   if (started) state_nx = S_FETCH;
      S_FETCH: begin
        read    = 1'b1;
        ir_load = bus.MEM_RDY;
        pc_inc  = bus.MEM_RDY;
      end
      S_DECODE: begin
        if (dec_bad) begin
          err_nx[1] = 1'b1;
          state_nx  = S_HALT;
        end else if (dec_halt) begin
          state_nx  = S_HALT;
        end else begin
          state_nx  = S_EXE;
        end
      end
      S_EXE: begin
        alu_op      = ALU_OP_W'(alu);
        alu_src_imm = imm;
        state_nx    = (mem_access || SKIP_MEM == 0) ? S_MEM : S_WB;
      end
      S_MEM: begin
        read  = (kind == K_LW);
        write = (kind == K_SW);
        if (!mem_access) state_nx = S_WB;
      end
      S_WB: begin
        reg_we     = (kind == K_RALU) || (kind == K_IARITH) || (kind == K_LW) || (kind == K_JAL);
        wb_sel_mem = (kind == K_LW);
        pc_load    = (kind == K_J) || (kind == K_JAL) || (kind == K_JR) ||
                     ((kind == K_BEQ) && zero_q) || ((kind == K_BNE) && !zero_q);
        state_nx   = S_FETCH;
      end
      S_HALT:   halted = 1'b1;
      default:  state_nx = S_IDLE;
    endcase

    // A ready on the final allowed wait cycle still completes the access.
    if (waiting) begin
      if (bus.MEM_RDY) begin
        cnt_nx   = '0;
        state_nx = (state == S_FETCH) ? S_DECODE : S_WB;
      end else if (MEM_TIMEOUT > 0) begin
        if (cnt == CNT_LAST) begin
          err_nx[0] = 1'b1;
          cnt_nx    = '0;
          state_nx  = S_HALT;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
    end
  end

  assign bus.READ        = read;
  assign bus.WRITE       = write;
  assign bus.IR_LOAD     = ir_load;
  assign bus.PC_INC      = pc_inc;
  assign bus.PC_LOAD     = pc_load;
  assign bus.REG_WE      = reg_we;
  assign bus.WB_SEL_MEM  = wb_sel_mem;
  assign bus.ALU_SRC_IMM = alu_src_imm;
  assign bus.ALU_OP      = alu_op;
  assign bus.STATE       = state;
  assign bus.HALTED      = halted;
  assign bus.ERR         = err;

endmodule
`default_nettype wire

// File: tb/tb_proc_ctrl_seq.sv
`default_nettype none
// tb_proc_ctrl_seq: directed program, cycle-by-cycle expected trace built from an instruction-level model.
// Rev 1.0
module tb_proc_ctrl_seq;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  proc_ctrl_seq_if #(.DATA_W(32), .ALU_OP_W(6)) bus ();

  proc_ctrl_seq #(
    .DATA_W(32), .ALU_OP_W(6), .MEM_TIMEOUT(15), .SKIP_MEM(1)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  typedef struct {
    bit          rst;
    bit          rst_mid;
    bit          rdy;
    logic [31:0] ins;
    bit          zero;
    int          st;
    bit          rd, wr, irl, pci, pcl, we, wbm, imm, hlt;
    int          op;
    int          err;
  } cyc_t;

  cyc_t       plan[$];
  cyc_t       c;
  logic [1:0] m_err;
  int         n_pass = 0;
  int         n_tot  = 0;
  int         cnt_pci = 0, cnt_pcl = 0, cnt_we = 0, cnt_wr = 0, cnt_wbm = 0;

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got 0x%0h, want 0x%0h", nm, idx, act, exp);
  endtask

  // Instruction-level semantics straight from the ISA table.
  function automatic void model_dec(input logic [31:0] w, output int alu, output bit imm,
                                    output bit ok, output bit hlt, output bit we, output bit wbm,
                                    output bit lw, output bit sw, output bit jmp,
                                    output bit beq, output bit bne);
    logic [5:0] opc;
    logic [5:0] fn;
    opc = w[31:26];
    fn  = w[5:0];
    alu = 0; imm = 0; ok = 1; hlt = 0; we = 0; wbm = 0;
    lw = 0; sw = 0; jmp = 0; beq = 0; bne = 0;
    case (opc)
      6'h00: begin
        we = 1;
        case (fn)
          6'h20: alu = 1;  6'h22: alu = 2;  6'h2c: alu = 3;
          6'h02: alu = 4;  6'h01: alu = 5;  6'h24: alu = 6;
          6'h25: alu = 7;  6'h27: alu = 8;  6'h2a: alu = 9;
          6'h08: begin we = 0; jmp = 1; end
          default: ok = 0;
        endcase
      end
      6'h08: begin alu = 1; imm = 1; we = 1; end
      6'h1d: begin alu = 3; imm = 1; we = 1; end
      6'h0c: begin alu = 6; imm = 1; we = 1; end
      6'h0d: begin alu = 7; imm = 1; we = 1; end
      6'h0a: begin alu = 9; imm = 1; we = 1; end
      6'h23: begin alu = 1; imm = 1; we = 1; wbm = 1; lw = 1; end
      6'h2b: begin alu = 1; imm = 1; sw = 1; end
      6'h04: begin alu = 2; beq = 1; end
      6'h05: begin alu = 2; bne = 1; end
      6'h02: jmp = 1;
      6'h03: begin jmp = 1; we = 1; end
      6'h3f: hlt = 1;
      default: ok = 0;
    endcase
  endfunction

  task automatic clr();
    c = '{rst: 1, rst_mid: 0, rdy: 0, ins: 32'h0, zero: 0, st: 0,
          rd: 0, wr: 0, irl: 0, pci: 0, pcl: 0, we: 0, wbm: 0, imm: 0, hlt: 0,
          op: 0, err: int'(m_err)};
  endtask

  task automatic push();
    plan.push_back(c);
  endtask

  task automatic do_reset(input int n);
    m_err = 2'b00;
    for (int i = 0; i < n; i++) begin clr(); c.rst = 0; push(); end
    clr(); push();   // release cycle
    clr(); push();   // IDLE cycle
  endtask

  task automatic do_halt(input int n);
    for (int i = 0; i < n; i++) begin clr(); c.st = 6; c.hlt = 1; c.rdy = 1; push(); end
  endtask

  task automatic fetch(input logic [31:0] w, input int fd);
    for (int i = 0; i < fd; i++) begin clr(); c.st = 1; c.rd = 1; push(); end
    clr(); c.st = 1; c.rd = 1; c.rdy = 1; c.ins = w; c.irl = 1; c.pci = 1; push();
  endtask

  task automatic do_instr(input logic [31:0] w, input int fd, input int md, input bit z);
    int alu; bit imm, ok, hlt, we, wbm, lw, sw, jmp, beq, bne;
    model_dec(w, alu, imm, ok, hlt, we, wbm, lw, sw, jmp, beq, bne);
    fetch(w, fd);
    clr(); c.st = 2; push();
    if (!ok) m_err[1] = 1'b1;
    if (!ok || hlt) begin do_halt(3); return; end
    clr(); c.st = 3; c.op = alu; c.imm = imm; c.zero = z; push();
    if (lw || sw) begin
      for (int i = 0; i <= md; i++) begin
        clr(); c.st = 4; c.rd = lw; c.wr = sw; c.rdy = (i == md); push();
      end
    end
    clr(); c.st = 5; c.we = we; c.wbm = wbm;
    c.pcl = jmp || (beq && z) || (bne && !z);
    push();
  endtask

  task automatic do_stuck();
    for (int i = 0; i < 15; i++) begin clr(); c.st = 1; c.rd = 1; push(); end
    m_err[0] = 1'b1;
  endtask

  // sw stalls in MEM and reset lands in the middle of its second stall cycle.
  task automatic do_sw_reset();
    fetch(32'hAC000000, 0);
    clr(); c.st = 2; push();
    clr(); c.st = 3; c.op = 1; c.imm = 1; push();
    clr(); c.st = 4; c.wr = 1; push();
    clr(); c.st = 4; c.wr = 1; c.rst_mid = 1; push();
  endtask

  initial begin
    m_err = 2'b00;
    do_reset(2);
    repeat (3) do_instr(32'h00000020, 0, 0, 0);   // add
    do_instr(32'h8C000000, 0, 3, 0);              // lw, 3 stall cycles in MEM
    do_instr(32'h10000000, 0, 0, 1);              // beq taken
    do_instr(32'h10000000, 0, 0, 0);              // beq not taken
    do_instr(32'h20000005, 2, 0, 0);              // addi, fetch stalls 2
    do_instr(32'h14000000, 0, 0, 0);              // bne taken
    do_instr(32'h08000000, 0, 0, 0);              // j
    do_instr(32'h0C000000, 0, 0, 1);              // jal
    do_instr(32'h00000008, 0, 0, 0);              // jr
    do_instr(32'h00000022, 0, 0, 0);              // sub
    do_instr(32'hAC000000, 0, 1, 0);              // sw, 1 stall
    do_instr(32'h00000025, 14, 0, 0);             // or, ready on 15th fetch cycle
    do_instr(32'hFC000000, 0, 0, 0);              // halt
    do_reset(2);
    do_instr(32'hF8000000, 0, 0, 0);              // illegal opcode 0x3e
    do_reset(2);
    do_instr(32'h00000020, 0, 0, 0);
    do_stuck();
    do_halt(4);
    do_reset(2);
    do_sw_reset();
    do_reset(2);
    do_instr(32'h00000020, 0, 0, 0);
    do_reset(1);
    do_instr(32'h00000003, 0, 0, 0);              // illegal R-type funct

    bus.MEM_RDY = 1'b0; bus.INSTRUCTION = '0; bus.ZERO = 1'b0;
    foreach (plan[i]) begin
      @(posedge CLK); #1;
      RST             = plan[i].rst;
      bus.MEM_RDY     = plan[i].rdy;
      bus.INSTRUCTION = plan[i].ins;
      bus.ZERO        = plan[i].zero;
      @(negedge CLK);
      chk("STATE",       i, 32'(bus.STATE),       plan[i].st);
      chk("READ",        i, 32'(bus.READ),        32'(plan[i].rd));
      chk("WRITE",       i, 32'(bus.WRITE),       32'(plan[i].wr));
      chk("IR_LOAD",     i, 32'(bus.IR_LOAD),     32'(plan[i].irl));
      chk("PC_INC",      i, 32'(bus.PC_INC),      32'(plan[i].pci));
      chk("PC_LOAD",     i, 32'(bus.PC_LOAD),     32'(plan[i].pcl));
      chk("REG_WE",      i, 32'(bus.REG_WE),      32'(plan[i].we));
      chk("WB_SEL_MEM",  i, 32'(bus.WB_SEL_MEM),  32'(plan[i].wbm));
      chk("ALU_SRC_IMM", i, 32'(bus.ALU_SRC_IMM), 32'(plan[i].imm));
      chk("ALU_OP",      i, 32'(bus.ALU_OP),      plan[i].op);
      chk("HALTED",      i, 32'(bus.HALTED),      32'(plan[i].hlt));
      chk("ERR",         i, 32'(bus.ERR),         plan[i].err);
      if (bus.PC_INC === 1'b1)     cnt_pci++;
      if (bus.PC_LOAD === 1'b1)    cnt_pcl++;
      if (bus.REG_WE === 1'b1)     cnt_we++;
      if (bus.WRITE === 1'b1)      cnt_wr++;
      if (bus.WB_SEL_MEM === 1'b1) cnt_wbm++;
      if (plan[i].rst_mid) begin
        #2 RST = 1'b0;
        #1;
        chk("async_rst_WRITE", i, 32'(bus.WRITE), 32'd0);
        chk("async_rst_READ",  i, 32'(bus.READ),  32'd0);
        chk("async_rst_STATE", i, 32'(bus.STATE), 32'd0);
        chk("async_rst_ERR",   i, 32'(bus.ERR),   32'd0);
      end
    end

    // Program totals counted by hand from the instruction list above.
    chk("total_PC_INC",     -1, cnt_pci, 32'd20);
    chk("total_PC_LOAD",    -1, cnt_pcl, 32'd5);
    chk("total_REG_WE",     -1, cnt_we,  32'd10);
    chk("total_WRITE",      -1, cnt_wr,  32'd4);
    chk("total_WB_SEL_MEM", -1, cnt_wbm, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/proc_ctrl_seq.md
Name: proc_ctrl_seq

Overview:
Parametrised multi-cycle control sequencer for the processor datapath: IDLE, FETCH, DECODE, EXE, MEM, WB, HALT.
- Latches the instruction into an internal IR and decodes it.
- Drives discrete datapath strobes and ALU op, and handshakes every memory access through MEM_RDY.
- Optionally skips MEM for non-memory instructions.
- Detects memory timeouts, illegal opcodes and halt.
- Sits between instruction/data memory and the register file/ALU/PC datapath.

Parameters:
DATA_W, 32, instruction width (>=32; opcode = IR[31:26], funct = IR[5:0])
ALU_OP_W, 6, width of ALU_OP output
MEM_TIMEOUT, 15, max wait cycles for MEM_RDY in FETCH/MEM; 0 disables timeout
SKIP_MEM, 1, 1: non-load/store go EXE->WB; 0: every instruction passes MEM (1 cycle, no strobes)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, asynchronous, active-low
INSTRUCTION  in  DATA_W  memory read data, valid when MEM_RDY=1 in FETCH
ZERO  in  1  ALU zero flag, sampled on last EXE cycle
MEM_RDY  in  1  memory done/ready for current READ/WRITE
READ  out  1  memory read request
WRITE  out  1  memory write request
IR_LOAD  out  1  IR capture strobe
PC_INC  out  1  PC+1 strobe
PC_LOAD  out  1  PC load (jump/branch target)
REG_WE  out  1  register-file write enable
WB_SEL_MEM  out  1  1: write-back data from memory, 0: from ALU
ALU_SRC_IMM  out  1  1: ALU B operand is immediate
ALU_OP  out  ALU_OP_W  ALU operation code
STATE  out  3  IDLE=0 FETCH=1 DECODE=2 EXE=3 MEM=4 WB=5 HALT=6
HALTED  out  1  sequencer in HALT
ERR  out  2  sticky: [0] memory timeout, [1] illegal opcode

Behaviour:
- RST low (any time, async): STATE=IDLE; IR, decode regs, wait counter, ERR cleared; all outputs 0 immediately, including mid-FETCH/MEM.
- IDLE: one cycle after RST release, then FETCH.
- FETCH:
  - READ=1.
  - MEM_RDY=0: stay, counter+1.
  - MEM_RDY=1: IR_LOAD=1 and PC_INC=1 combinationally that cycle; IR<=INSTRUCTION on that edge; ->DECODE; counter cleared.
- DECODE (1 cycle): classify IR and register class/ALU_OP; no strobes.
  - R-type (op 0x00) funct -> ALU_OP: 0x20 add=1, 0x22 sub=2, 0x2c mul=3, 0x02 srl=4, 0x01 sll=5, 0x24 and=6, 0x25 or=7, 0x27 nor=8, 0x2a slt=9, 0x08 jr=0.
  - I-arith: addi 0x08->1, muli 0x1d->3, andi 0x0c->6, ori 0x0d->7, slti 0x0a->9; ALU_SRC_IMM=1.
  - lw 0x23, sw 0x2b: ALU_OP=1, ALU_SRC_IMM=1.
  - beq 0x04, bne 0x05: ALU_OP=2.
  - j 0x02, jal 0x03: ALU_OP=0.
  - halt 0x3f: ->HALT, ERR unchanged.
  - Any other opcode or R-type funct: ERR[1]=1, ->HALT.
- EXE (1 cycle):
  - ALU_OP and ALU_SRC_IMM driven.
  - ZERO registered on exit.
  - Next: MEM if lw/sw or SKIP_MEM=0, else WB.
- MEM:
  - lw: READ=1.
  - sw: WRITE=1.
  - Other instructions (SKIP_MEM=0 only): no strobe, one cycle.
  - lw/sw wait on MEM_RDY exactly as FETCH; ->WB on MEM_RDY=1.
- WB (1 cycle), then FETCH:
  - REG_WE=1 for R-type except jr, I-arith, lw, jal.
  - WB_SEL_MEM=1 for lw only.
  - PC_LOAD=1 for j, jal, jr, beq with ZERO=1, bne with ZERO=0.
- Timeout (MEM_TIMEOUT>0):
  - Counter counts consecutive MEM_RDY=0 cycles in FETCH/MEM.
  - On the edge where counter reaches MEM_TIMEOUT with MEM_RDY still 0: ERR[0]=1, ->HALT.
  - MEM_RDY=1 in that same cycle wins; no error.
- HALT: absorbing until RST; HALTED=1; all strobes 0; ALU_OP=0.
- Outputs are a Moore function of STATE + registered decode, except IR_LOAD/PC_INC (FETCH & MEM_RDY).
- READ and WRITE are never both 1.
- Throughput with MEM_RDY tied 1: 4 cycles/ALU instr (SKIP_MEM=1), 5 (SKIP_MEM=0); lw/sw always 5.

Test Plan:
- Reset release, MEM_RDY=1, add (0x00..20) stream, SKIP_MEM=1 -> STATE 1,2,3,5 repeating; ALU_OP=1 in EXE; REG_WE=1 only in WB; PC_INC every 4th cycle.
- lw (op 0x23) with MEM_RDY low 3 cycles in MEM -> READ held 4 cycles; WB asserts REG_WE=1, WB_SEL_MEM=1; ERR=0.
- beq with ZERO=1, then beq with ZERO=0 -> PC_LOAD=1 in first WB only; REG_WE=0 both.
- MEM_TIMEOUT=15, MEM_RDY stuck 0 in FETCH -> ERR=2'b01 and HALTED=1 after 15 cycles; stays until RST; MEM_RDY=1 on the 15th cycle -> no error.
- Opcode 0x3e -> ERR=2'b10, HALT after DECODE; opcode 0x3f -> HALT, ERR=0.
- RST low during sw in MEM -> WRITE drops same cycle; STATE=0, ERR=0; FETCH on second edge after release.
